// File: rtl/regfile.sv
// Renaming register file: operand read with commit bypass, destination rename, commit retire.
// Optional REGFILE_COMMIT_CNT_EN adds a free-running commit counter on oDbg_Cnt.
module regfile #(
  parameter int REG_ADD_W = 5,
  parameter int REG_DAT_W = 32,
  parameter int ROB_ADD_W = 4,
  parameter int INS_OP_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iIS_En,
  input  logic [REG_ADD_W-1:0] iIS_Rs1,
  input  logic [REG_ADD_W-1:0] iIS_Rs2,
  input  logic [REG_ADD_W-1:0] iIS_Rd,
  input  logic [INS_OP_W-1:0]  iIS_Op,
  input  logic [REG_DAT_W-1:0] iIS_Pc,
  input  logic [REG_DAT_W-1:0] iIS_Imm,
  input  logic                 iIS_Ils,
  input  logic [ROB_ADD_W-1:0] iROB_Qn,
  output logic                 oROB_En,
  output logic [ROB_ADD_W-1:0] oROB_Qs1,
  output logic [ROB_ADD_W-1:0] oROB_Qs2,
  output logic [REG_DAT_W-1:0] oROB_Vs1,
  output logic [REG_DAT_W-1:0] oROB_Vs2,
  output logic [ROB_ADD_W-1:0] oROB_Qd,
  output logic [INS_OP_W-1:0]  oROB_Op,
  output logic [REG_DAT_W-1:0] oROB_Pc,
  output logic [REG_DAT_W-1:0] oROB_Imm,
  output logic                 oROB_Ils,
  input  logic                 iROB_En,
  input  logic [REG_ADD_W-1:0] iROB_Rd,
  input  logic [REG_DAT_W-1:0] iROB_Vd,
  input  logic [ROB_ADD_W-1:0] iROB_Qc,
  input  logic                 iMp
`ifdef REGFILE_COMMIT_CNT_EN
  ,
  output logic [31:0]          oDbg_Cnt
`endif
);

  localparam int NREG = 1 << REG_ADD_W;
  localparam int SW   = ROB_ADD_W + REG_DAT_W;

  logic [REG_DAT_W-1:0] val_q [NREG];
  logic [REG_DAT_W-1:0] val_d [NREG];
  logic [ROB_ADD_W-1:0] tag_q [NREG];
  logic [ROB_ADD_W-1:0] tag_d [NREG];

  logic                 en_q;
  logic [ROB_ADD_W-1:0] qs1_q, qs2_q, qd_q;
  logic [REG_DAT_W-1:0] vs1_q, vs2_q, pc_q, imm_q;
  logic [INS_OP_W-1:0]  op_q;
  logic                 ils_q;

  logic [SW-1:0]        s1_d, s2_d;
  logic                 act, cmt, ren;

  // Commit may complete in the same cycle as the read: forward it.
  function automatic logic [SW-1:0] rd_src(
    input logic [REG_ADD_W-1:0] rs,
    input logic [ROB_ADD_W-1:0] t,
    input logic [REG_DAT_W-1:0] v,
    input logic                 c_en,
    input logic [REG_ADD_W-1:0] c_rd,
    input logic [ROB_ADD_W-1:0] c_q,
    input logic [REG_DAT_W-1:0] c_v
  );
    logic [SW-1:0] r;
    r = '0;
    if (rs == '0)
      r = '0;
    else if (c_en && c_rd == rs && t == c_q)
      r = {{ROB_ADD_W{1'b0}}, c_v};
    else if (t != '0)
      r = {t, {REG_DAT_W{1'b0}}};
    else
      r = {{ROB_ADD_W{1'b0}}, v};
    return r;
  endfunction

  assign act = en | iMp;
  assign cmt = act & iROB_En & (iROB_Rd != '0);
  assign ren = en & ~iMp & iIS_En & (iIS_Rd != '0);

  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (cmt) begin
      val_d[iROB_Rd] = iROB_Vd;
      if (tag_q[iROB_Rd] == iROB_Qc)
        tag_d[iROB_Rd] = '0;
    end
    if (ren)
      tag_d[iIS_Rd] = iROB_Qn;
    if (iMp)
      for (int i = 0; i < NREG; i++)
        tag_d[i] = '0;
    val_d[0] = '0;
    tag_d[0] = '0;
  end

  always_comb begin
    s1_d = rd_src(iIS_Rs1, tag_q[iIS_Rs1], val_q[iIS_Rs1],
                  iROB_En, iROB_Rd, iROB_Qc, iROB_Vd);
    s2_d = rd_src(iIS_Rs2, tag_q[iIS_Rs2], val_q[iIS_Rs2],
                  iROB_En, iROB_Rd, iROB_Qc, iROB_Vd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (act) begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= 1'b0;
      qs1_q <= '0;
      qs2_q <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
      qd_q  <= '0;
      op_q  <= '0;
      pc_q  <= '0;
      imm_q <= '0;
      ils_q <= 1'b0;
    end else if (iMp) begin
      en_q <= 1'b0;
    end else if (en) begin
      en_q <= iIS_En;
      if (iIS_En) begin
        {qs1_q, vs1_q} <= s1_d;
        {qs2_q, vs2_q} <= s2_d;
        qd_q  <= iROB_Qn;
        op_q  <= iIS_Op;
        pc_q  <= iIS_Pc;
        imm_q <= iIS_Imm;
        ils_q <= iIS_Ils;
      end
    end
  end

  assign oROB_En  = en_q;
  assign oROB_Qs1 = qs1_q;
  assign oROB_Qs2 = qs2_q;
  assign oROB_Vs1 = vs1_q;
  assign oROB_Vs2 = vs2_q;
  assign oROB_Qd  = qd_q;
  assign oROB_Op  = op_q;
  assign oROB_Pc  = pc_q;
  assign oROB_Imm = imm_q;
  assign oROB_Ils = ils_q;

`ifdef REGFILE_COMMIT_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (en && iROB_En && iROB_Rd != '0)
      cnt_q <= cnt_d;
  end

  assign oDbg_Cnt = cnt_q;
`endif

endmodule

// File: tb/tb_regfile.sv
// Testbench for regfile: directed scenarios then random traffic
// checked against an array-based reference model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        iIS_En, iIS_Ils, iROB_En, iMp;
  logic [4:0]  iIS_Rs1, iIS_Rs2, iIS_Rd, iROB_Rd;
  logic [5:0]  iIS_Op;
  logic [31:0] iIS_Pc, iIS_Imm, iROB_Vd;
  logic [3:0]  iROB_Qn, iROB_Qc;
  logic        oROB_En, oROB_Ils;
  logic [3:0]  oROB_Qs1, oROB_Qs2, oROB_Qd;
  logic [31:0] oROB_Vs1, oROB_Vs2, oROB_Pc, oROB_Imm;
  logic [5:0]  oROB_Op;
`ifdef REGFILE_COMMIT_CNT_EN
  logic [31:0] oDbg_Cnt;
`endif

  regfile dut (
    .clk(clk), .rst(rst), .en(en),
    .iIS_En(iIS_En), .iIS_Rs1(iIS_Rs1), .iIS_Rs2(iIS_Rs2),
    .iIS_Rd(iIS_Rd), .iIS_Op(iIS_Op), .iIS_Pc(iIS_Pc),
    .iIS_Imm(iIS_Imm), .iIS_Ils(iIS_Ils), .iROB_Qn(iROB_Qn),
    .oROB_En(oROB_En), .oROB_Qs1(oROB_Qs1), .oROB_Qs2(oROB_Qs2),
    .oROB_Vs1(oROB_Vs1), .oROB_Vs2(oROB_Vs2), .oROB_Qd(oROB_Qd),
    .oROB_Op(oROB_Op), .oROB_Pc(oROB_Pc), .oROB_Imm(oROB_Imm),
    .oROB_Ils(oROB_Ils), .iROB_En(iROB_En), .iROB_Rd(iROB_Rd),
    .iROB_Vd(iROB_Vd), .iROB_Qc(iROB_Qc), .iMp(iMp)
`ifdef REGFILE_COMMIT_CNT_EN
    , .oDbg_Cnt(oDbg_Cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  logic [31:0] mval [32];
  logic [3:0]  mtag [32];
  logic [31:0] mcnt;
  logic        e_en, e_ils;
  logic [3:0]  e_qs1, e_qs2, e_qd;
  logic [31:0] e_vs1, e_vs2, e_pc, e_imm;
  logic [5:0]  e_op;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 32; i++) begin
      mval[i] = '0;
      mtag[i] = '0;
    end
    mcnt = '0;
    {e_en, e_ils, e_qs1, e_qs2, e_qd} = '0;
    {e_vs1, e_vs2, e_pc, e_imm, e_op} = '0;
  endtask

  task automatic idle();
    en = 1'b1; iMp = 1'b0;
    iIS_En = 1'b0; iIS_Rs1 = '0; iIS_Rs2 = '0; iIS_Rd = '0;
    iIS_Op = '0; iIS_Pc = '0; iIS_Imm = '0; iIS_Ils = 1'b0;
    iROB_Qn = '0;
    iROB_En = 1'b0; iROB_Rd = '0; iROB_Vd = '0; iROB_Qc = '0;
  endtask

  function automatic logic [35:0] msrc(input logic [4:0] rs);
    if (rs == 0) return '0;
    if (iROB_En && iROB_Rd == rs && mtag[rs] == iROB_Qc)
      return {4'd0, iROB_Vd};
    if (mtag[rs] != 0) return {mtag[rs], 32'd0};
    return {4'd0, mval[rs]};
  endfunction

  task automatic check_outs(input string p);
    chk({p, "_en"},  {31'd0, oROB_En}, {31'd0, e_en});
    chk({p, "_qs1"}, {28'd0, oROB_Qs1}, {28'd0, e_qs1});
    chk({p, "_vs1"}, oROB_Vs1, e_vs1);
    chk({p, "_qs2"}, {28'd0, oROB_Qs2}, {28'd0, e_qs2});
    chk({p, "_vs2"}, oROB_Vs2, e_vs2);
    chk({p, "_qd"},  {28'd0, oROB_Qd}, {28'd0, e_qd});
    chk({p, "_op"},  {26'd0, oROB_Op}, {26'd0, e_op});
    chk({p, "_pc"},  oROB_Pc, e_pc);
    chk({p, "_imm"}, oROB_Imm, e_imm);
    chk({p, "_ils"}, {31'd0, oROB_Ils}, {31'd0, e_ils});
`ifdef REGFILE_COMMIT_CNT_EN
    chk({p, "_cnt"}, oDbg_Cnt, mcnt);
`endif
  endtask

  // Called at negedge with inputs applied; returns at the next negedge.
  task automatic step(input string p);
    if (iMp) begin
      e_en = 1'b0;
    end else if (en) begin
      e_en = iIS_En;
      if (iIS_En) begin
        {e_qs1, e_vs1} = msrc(iIS_Rs1);
        {e_qs2, e_vs2} = msrc(iIS_Rs2);
        e_qd = iROB_Qn; e_op = iIS_Op; e_pc = iIS_Pc;
        e_imm = iIS_Imm; e_ils = iIS_Ils;
      end
    end
    if ((en || iMp) && iROB_En && iROB_Rd != 0) begin
      mval[iROB_Rd] = iROB_Vd;
      if (mtag[iROB_Rd] == iROB_Qc) mtag[iROB_Rd] = 0;
    end
    if (en && iROB_En && iROB_Rd != 0) mcnt = mcnt + 1;
    if (en && !iMp && iIS_En && iIS_Rd != 0) mtag[iIS_Rd] = iROB_Qn;
    if (iMp)
      for (int i = 0; i < 32; i++) mtag[i] = 0;
    @(posedge clk);
    #1;
    check_outs(p);
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [3:0] qn);
    iIS_En = 1'b1; iIS_Rs1 = r1; iIS_Rs2 = r2; iIS_Rd = rd;
    iROB_Qn = qn; iIS_Op = 6'h2a; iIS_Pc = 32'h100 + qn;
    iIS_Imm = 32'hff00 | r1; iIS_Ils = rd[0];
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] qc,
                        input logic [31:0] vd);
    iROB_En = 1'b1; iROB_Rd = rd; iROB_Qc = qc; iROB_Vd = vd;
  endtask

  initial begin
    idle();
    mreset();
    rst = 1'b1;
    #2;
    check_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    // rename with clean sources
    issue(1, 2, 3, 5); step("tp1");
    chk("tp1_en", {31'd0, oROB_En}, 32'd1);
    chk("tp1_qd", {28'd0, oROB_Qd}, 32'd5);
    chk("tp1_qs1", {28'd0, oROB_Qs1}, 32'd0);

    // read pending tag, then commit and reread
    idle(); issue(3, 0, 0, 1); step("tp2a");
    chk("tp2_qs1", {28'd0, oROB_Qs1}, 32'd5);
    chk("tp2_vs1", oROB_Vs1, 32'd0);
    idle(); commit(3, 5, 32'h1234); step("tp2b");
    idle(); issue(3, 0, 0, 2); step("tp2c");
    chk("tp2_qs1c", {28'd0, oROB_Qs1}, 32'd0);
    chk("tp2_vs1c", oROB_Vs1, 32'h1234);

    // same-cycle bypass
    idle(); issue(0, 0, 3, 5); step("tp3a");
    idle(); issue(3, 0, 0, 1); commit(3, 5, 32'haa); step("tp3b");
    chk("tp3_qs1", {28'd0, oROB_Qs1}, 32'd0);
    chk("tp3_vs1", oROB_Vs1, 32'haa);

    // younger producer keeps ownership
    idle(); issue(0, 0, 4, 6); step("tp4a");
    idle(); issue(0, 0, 4, 7); step("tp4b");
    idle(); commit(4, 6, 32'd9); step("tp4c");
    idle(); issue(4, 0, 0, 1); step("tp4d");
    chk("tp4_qs1", {28'd0, oROB_Qs1}, 32'd7);

    // x0 is never renamed
    idle(); issue(0, 0, 0, 2); step("tp5a");
    idle(); issue(0, 0, 0, 3); step("tp5b");
    chk("tp5_qs1", {28'd0, oROB_Qs1}, 32'd0);
    chk("tp5_vs1", oROB_Vs1, 32'd0);

    // same-cycle commit and rename of one register
    idle(); issue(0, 0, 6, 8); commit(6, 0, 32'h66); step("tp6a");
    idle(); issue(6, 6, 0, 1); step("tp6b");
    chk("same_rd_q", {28'd0, oROB_Qs1}, 32'd8);

    // Rs==Rd sees the old mapping
    idle(); issue(2, 0, 2, 9); step("rsrd_a");
    chk("rsrd_q", {28'd0, oROB_Qs1}, 32'd0);

    // flush with tags on x1..x5 and an issue in flight
    for (int r = 1; r <= 5; r++) begin
      idle(); issue(0, 0, r[4:0], 4'(r + 8)); step("fl_set");
    end
    idle(); issue(1, 2, 7, 3); iMp = 1'b1; step("flush");
    chk("flush_en", {31'd0, oROB_En}, 32'd0);
    idle(); issue(4, 3, 0, 2); step("fl_rd");
    chk("fl_q4", {28'd0, oROB_Qs1}, 32'd0);
    chk("fl_v4", oROB_Vs1, 32'd9);
    chk("fl_v3", oROB_Vs2, 32'haa);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] crd;
      idle();
      en = ($urandom_range(0, 9) != 0);
      iIS_En = ($urandom_range(0, 3) != 0);
      iIS_Rs1 = 5'($urandom_range(0, 7));
      iIS_Rs2 = 5'($urandom_range(0, 7));
      iIS_Rd = 5'($urandom_range(0, 7));
      iIS_Op = 6'($urandom);
      iIS_Pc = $urandom;
      iIS_Imm = $urandom;
      iIS_Ils = 1'($urandom);
      iROB_Qn = 4'($urandom_range(1, 15));
      crd = 5'($urandom_range(0, 7));
      iROB_En = ($urandom_range(0, 1) != 0);
      iROB_Rd = crd;
      iROB_Vd = $urandom;
      iROB_Qc = ($urandom_range(0, 9) < 7) ? mtag[crd]
                                            : 4'($urandom);
      iMp = en && ($urandom_range(0, 39) == 0);
      step("rnd");
    end

    // asynchronous reset mid-cycle
    idle(); issue(1, 0, 2, 3); step("ar_pre");
    rst = 1'b1;
    #1;
    mreset();
    chk("arst_en", {31'd0, oROB_En}, 32'd0);
    chk("arst_qd", {28'd0, oROB_Qd}, 32'd0);
    check_outs("arst");
    idle();
    @(negedge clk);
    rst = 1'b0;
    issue(2, 0, 0, 1); step("post_rst");
    chk("post_rst_q2", {28'd0, oROB_Qs1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
